// File: rtl/channel_fill_4.sv
// channel_fill_4: reads one seed word from the seed channel, then writes COUNT
// words (seed, seed+STEP, ...) into the output channel and raises valid.
module channel_fill_4 #(
  parameter int unsigned             WIDTH = 32,
  parameter int unsigned             COUNT = 4,
  parameter logic [WIDTH-1:0]        STEP  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_in_data,
  output logic             out_read_valid,
  output logic             out_rst,
  output logic             out_write_valid,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  input  logic             out_write_ready,
  output logic [WIDTH-1:0] seed_in_data,
  output logic             seed_read_valid,
  output logic             seed_rst,
  output logic             seed_write_valid,
  input  logic [WIDTH-1:0] seed_out_data,
  input  logic             seed_read_ready,
  input  logic             seed_write_ready,
  output logic             valid
);

  localparam int unsigned CW = $clog2(COUNT + 1);
  // cnt == LAST is the same test as cnt+1 == COUNT without widening the sum
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [2:0] {
    INIT,
    WAIT_SEED,
    READ_SEED,
    CAPTURE,
    WAIT_OUT,
    WRITE,
    INCR,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] value;
  logic [CW-1:0]    cnt;

  logic unused_inputs;
  assign unused_inputs = ^{out_out_data, out_read_ready, seed_write_ready};

  // Channel lines this stage never drives
  assign out_read_valid   = 1'b0;
  assign out_rst          = 1'b0;
  assign seed_in_data     = '0;
  assign seed_rst         = 1'b0;
  assign seed_write_valid = 1'b0;
  assign out_in_data      = value;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  // Datapath: seed capture, running value and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        INIT:    cnt   <= '0;
        CAPTURE: value <= seed_out_data;
        INCR: begin
          value <= value + STEP;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_next      = state;
    seed_read_valid = 1'b0;
    out_write_valid = 1'b0;
    valid           = 1'b0;
    case (state)
      INIT:      state_next = WAIT_SEED;
      WAIT_SEED: if (seed_read_ready) state_next = READ_SEED;
      READ_SEED: begin
        seed_read_valid = 1'b1;
        state_next      = CAPTURE;
      end
      CAPTURE:   state_next = WAIT_OUT;
      WAIT_OUT:  if (out_write_ready) state_next = WRITE;
      WRITE: begin
        out_write_valid = 1'b1;
        state_next      = INCR;
      end
      INCR:      state_next = (cnt == LAST) ? DONE : WAIT_OUT;
      DONE:      valid = 1'b1;
      default:   state_next = INIT;
    endcase
  end

endmodule

// File: tb/tb_channel_fill_4.sv
// Directed bench for channel_fill_4 (WIDTH=32, COUNT=4, STEP=1).
module tb_channel_fill_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] out_in_data;
  logic        out_read_valid, out_rst, out_write_valid;
  logic [31:0] out_out_data;
  logic        out_read_ready, out_write_ready;
  logic [31:0] seed_in_data;
  logic        seed_read_valid, seed_rst, seed_write_valid;
  logic [31:0] seed_out_data;
  logic        seed_read_ready, seed_write_ready;
  logic        valid;

  channel_fill_4 #(.WIDTH(32), .COUNT(4), .STEP(32'd1)) dut (
    .clk              (clk),
    .rst              (rst),
    .out_in_data      (out_in_data),
    .out_read_valid   (out_read_valid),
    .out_rst          (out_rst),
    .out_write_valid  (out_write_valid),
    .out_out_data     (out_out_data),
    .out_read_ready   (out_read_ready),
    .out_write_ready  (out_write_ready),
    .seed_in_data     (seed_in_data),
    .seed_read_valid  (seed_read_valid),
    .seed_rst         (seed_rst),
    .seed_write_valid (seed_write_valid),
    .seed_out_data    (seed_out_data),
    .seed_read_ready  (seed_read_ready),
    .seed_write_ready (seed_write_ready),
    .valid            (valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Observations collected by run_fill
  logic [31:0] wr_dat [8];
  int          wr_cyc [8];
  int          nwr, nrd, rd_cyc, valid_cyc, valid_drop, tied_bad, order_bad;
  logic [31:0] sum;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Two reset edges; outputs checked after the first. Leaves the DUT in cycle 0 (INIT).
  task automatic do_reset();
    rst = 1'b1;
    seed_read_ready = 1'b0;
    out_write_ready = 1'b0;
    @(posedge clk); #1;
    check_val("rst_wr", {31'd0, out_write_valid}, 32'd0);
    check_val("rst_rd", {31'd0, seed_read_valid}, 32'd0);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_data", out_in_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs ncyc cycles starting from cycle 0 = INIT, recording strobes.
  // abort_at>0: pulse rst in the cycle after that many writes, then check outputs.
  task automatic run_fill(input logic [31:0] seed, input int delay, input bit toggle,
                          input int ncyc, input int abort_at);
    bit prev_ready;
    nwr = 0; nrd = 0; rd_cyc = -1; valid_cyc = -1;
    valid_drop = 0; tied_bad = 0; order_bad = 0; sum = '0;
    prev_ready = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      seed_read_ready = (c >= delay);
      out_write_ready = toggle ? (c % 2 == 1) : 1'b1;
      seed_out_data   = seed;
      if (out_write_valid) begin
        if (nwr < 8) begin
          wr_dat[nwr] = out_in_data;
          wr_cyc[nwr] = c;
        end
        if (!prev_ready) order_bad++;
        sum = sum + out_in_data;
        nwr++;
      end
      if (seed_read_valid) begin
        if (nrd == 0) rd_cyc = c;
        nrd++;
      end
      if (valid && valid_cyc < 0) valid_cyc = c;
      if (!valid && valid_cyc >= 0) valid_drop++;
      if (out_read_valid || out_rst || seed_rst || seed_write_valid || seed_in_data != 0)
        tied_bad++;
      prev_ready = out_write_ready;
      if (abort_at > 0 && nwr == abort_at && !out_write_valid) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_wr", {31'd0, out_write_valid}, 32'd0);
        check_val("abort_rd", {31'd0, seed_read_valid}, 32'd0);
        check_val("abort_valid", {31'd0, valid}, 32'd0);
        check_val("abort_data", out_in_data, 32'd0);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    out_out_data     = '0;
    out_read_ready   = 1'b0;
    seed_write_ready = 1'b0;
    seed_out_data    = '0;

    // Both readies high, seed 10
    do_reset();
    run_fill(32'd10, 0, 1'b0, 45, 0);
    check_val("t1_nrd", nrd, 1);
    check_val("t1_rdcyc", rd_cyc, 2);
    check_val("t1_nwr", nwr, 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t1_cyc%0d", i), wr_cyc[i], 5 + 3 * i);
      check_val($sformatf("t1_dat%0d", i), wr_dat[i], 32'd10 + i);
    end
    check_val("t1_valid", valid_cyc, 16);
    check_val("t1_hold", valid_drop, 0);
    check_val("t1_tied", tied_bad, 0);

    // Seed channel empty for 5 cycles
    do_reset();
    run_fill(32'd7, 6, 1'b0, 45, 0);
    check_val("t2_rdcyc", rd_cyc, 7);
    check_val("t2_nwr", nwr, 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("t2_dat%0d", i), wr_dat[i], 32'd7 + i);
    check_val("t2_valid", valid_cyc, 21);

    // Output ready toggling every cycle
    do_reset();
    run_fill(32'd0, 0, 1'b1, 60, 0);
    check_val("t3_nwr", nwr, 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("t3_dat%0d", i), wr_dat[i], i);
    check_val("t3_order", order_bad, 0);
    check_val("t3_done", {31'd0, valid}, 32'd1);

    // Wraparound
    do_reset();
    run_fill(32'hFFFF_FFFE, 0, 1'b0, 30, 0);
    check_val("t4_nwr", nwr, 4);
    check_val("t4_dat0", wr_dat[0], 32'hFFFF_FFFE);
    check_val("t4_dat1", wr_dat[1], 32'hFFFF_FFFF);
    check_val("t4_dat2", wr_dat[2], 32'h0000_0000);
    check_val("t4_dat3", wr_dat[3], 32'h0000_0001);

    // Reset between the 2nd and 3rd write, then a fresh run
    do_reset();
    run_fill(32'd10, 0, 1'b0, 30, 2);
    check_val("t5_pre_nwr", nwr, 2);
    run_fill(32'd100, 0, 1'b0, 40, 0);
    check_val("t5_nrd", nrd, 1);
    check_val("t5_rdcyc", rd_cyc, 2);
    check_val("t5_nwr", nwr, 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("t5_dat%0d", i), wr_dat[i], 32'd100 + i);
    check_val("t5_valid", valid_cyc, 16);

    // Downstream reduction of the written words, seed 5
    do_reset();
    run_fill(32'd5, 0, 1'b0, 30, 0);
    check_val("t6_sum", sum, 32'd26);
    check_val("t6_valid", valid_cyc, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
